// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        REPORT  = 2'd3
    } sweep_state_t;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;
    localparam int CNT_W       = 4;

    // Reference function of the lab unit: x = ~d ^ (a|s), y = a&s.
    localparam logic [NUM_VECTORS-1:0] GOLDEN_X = 8'hA9;
    localparam logic [NUM_VECTORS-1:0] GOLDEN_Y = 8'hC0;

    // Lowest set bit of a difference mask; 0 when the mask is clear.
    function automatic logic [IDX_W-1:0] first_mismatch(input logic [NUM_VECTORS-1:0] diff);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
            if (diff[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Bundle between the lab top-level, the sweeper and the logic unit under test.
interface truth_table_sweeper_if
    import sweep_pkg::*;
;
    logic                   start;
    logic                   abort;
    logic [NUM_VECTORS-1:0] exp_x;
    logic [NUM_VECTORS-1:0] exp_y;
    logic                   x_in;
    logic                   y_in;
    logic                   a_out;
    logic                   s_out;
    logic                   d_out;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic                   fail;
    logic [IDX_W-1:0]       mismatch_idx;
    logic [NUM_VECTORS-1:0] table_x;
    logic [NUM_VECTORS-1:0] table_y;

    // Sweeper side.
    modport slave (
        input  start, abort, exp_x, exp_y, x_in, y_in,
        output a_out, s_out, d_out, busy, done, pass, fail,
               mismatch_idx, table_x, table_y
    );

    // Lab top-level / logic-unit side.
    modport master (
        output start, abort, exp_x, exp_y, x_in, y_in,
        input  a_out, s_out, d_out, busy, done, pass, fail,
               mismatch_idx, table_x, table_y
    );
endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// Per-vector settle counter: counts while enabled, flags the last settle cycle.
module sweep_settle_timer
    import sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2   // legal range 1..15
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear has priority so an abort out of SETTLE leaves the counter at 0.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + CNT_W'(1);
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign expire_o = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps a 3-input unit through all 8 vectors, captures x/y into truth tables
// and grades them against the expected tables.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2   // legal range 1..15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    truth_table_sweeper_if.slave sw
);

    sweep_state_t           state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       vec_q, vec_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   fail_q, fail_d;
    logic [IDX_W-1:0]       mis_q, mis_d;
    logic [NUM_VECTORS-1:0] tx_q, tx_d;
    logic [NUM_VECTORS-1:0] ty_q, ty_d;
    logic                   tmr_clr, tmr_en, tmr_expire;
    logic                   match;

    sweep_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expire_o (tmr_expire)
    );

    assign match = (tx_q == sw.exp_x) && (ty_q == sw.exp_y);

    // Next-state and registered-output logic; abort overrides every active state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        fail_d  = fail_q;
        mis_d   = mis_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (sw.start && !sw.abort) begin
                    state_d = SETTLE;
                    idx_d   = '0;
                    tx_d    = '0;
                    ty_d    = '0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    mis_d   = '0;
                    busy_d  = 1'b1;
                    tmr_clr = 1'b1;
                end
            end
            SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_expire) state_d = CAPTURE;
            end
            CAPTURE: begin
                tx_d[idx_q] = sw.x_in;
                ty_d[idx_q] = sw.y_in;
                tmr_clr     = 1'b1;
                if (idx_q == IDX_W'(NUM_VECTORS - 1)) begin
                    state_d = REPORT;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = SETTLE;
                end
            end
            REPORT: begin
                pass_d  = match;
                fail_d  = !match;
                mis_d   = first_mismatch((tx_q ^ sw.exp_x) | (ty_q ^ sw.exp_y));
                done_d  = 1'b1;
                busy_d  = 1'b0;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort drops the sweep without a report; partial tables stay visible.
        if (sw.abort && state_q != IDLE) begin
            state_d = IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            mis_d   = '0;
            tx_d    = tx_q;
            ty_d    = ty_q;
            tmr_clr = 1'b1;
        end

        // Unit inputs come straight from a flop so they never glitch mid-vector.
        vec_d = (state_d == IDLE) ? '0 : idx_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            mis_q   <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            mis_q   <= mis_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
        end
    end

    assign sw.a_out        = vec_q[2];
    assign sw.s_out        = vec_q[1];
    assign sw.d_out        = vec_q[0];
    assign sw.busy         = busy_q;
    assign sw.done         = done_q;
    assign sw.pass         = pass_q;
    assign sw.fail         = fail_q;
    assign sw.mismatch_idx = mis_q;
    assign sw.table_x      = tx_q;
    assign sw.table_y      = ty_q;

endmodule
